uart_cmd_deframer: RTL and testbench

- Sits directly downstream of the UART byte receiver in the Segway command path.
- Consumes received bytes over the rx_data/rx_rdy handshake and assembles 5-byte command frames: SYNC, CMD, DATA_HI, DATA_LO, CHK.
- Validates each frame by checksum and by an inter-byte timeout.
- Presents validated commands to the control logic as cmd/data with a level ready flag that control logic clears.

---
 rtl/uart_cmd_deframer.sv | 173 +++++++++++++++++
 tb/tb_uart_cmd_deframer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_deframer.sv
//------------------------------------------------------------------------------
// Module      : uart_cmd_deframer
// Description : Assembles 5-byte command frames (SYNC, CMD, DATA_HI, DATA_LO,
//               CHK) from the UART receiver byte stream. Each frame is checked
//               by its checksum and by an inter-byte timeout. Validated
//               commands are presented as cmd/data with a level ready flag.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_cmd_deframer #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 65104
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        clr_rx_rdy,
    input  logic        clr_cmd_rdy,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_rdy,
    output logic        cmd_err,
    output logic [1:0]  err_type
);

    // Counter value on which a byte-less cycle becomes a timeout
    localparam logic [16:0] c_tmo_last = 17'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  c_err_chk  = 2'b01;
    localparam logic [1:0]  c_err_tmo  = 2'b10;
    localparam logic [1:0]  c_err_ovr  = 2'b11;
    localparam logic [7:0]  c_sum_ok   = 8'hFF;

    typedef enum logic [2:0] {
        ST_SYNC = 3'd0,
        ST_CMD  = 3'd1,
        ST_DHI  = 3'd2,
        ST_DLO  = 3'd3,
        ST_CHK  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cmd_h;
    logic [7:0]  r_dhi_h;
    logic [7:0]  r_dlo_h;
    logic [16:0] r_tmo_cnt;
    logic [7:0]  w_sum;
    logic        w_tmo_exp;
    logic        w_load;
    logic        w_err;
    logic [1:0]  w_err_type;

    // Every byte is consumed in the cycle it is presented
    assign clr_rx_rdy = rx_rdy;

    // 8-bit wrapping sum of the frame; a good frame sums to 0xFF
    assign w_sum = r_cmd_h + r_dhi_h + r_dlo_h + rx_data;

    // A byte arriving in the expiry cycle takes precedence over the timeout
    assign w_tmo_exp = (r_state != ST_SYNC) && !rx_rdy && (r_tmo_cnt == c_tmo_last);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, frame commit and error decode
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_err       = 1'b0;
        w_err_type  = 2'b00;
        case (r_state)
            ST_SYNC: begin
                if (rx_rdy && (rx_data == SYNC_BYTE)) begin
                    w_state_nxt = ST_CMD;
                end
            end
            ST_CMD, ST_DHI, ST_DLO: begin
                if (rx_rdy) begin
                    w_state_nxt = state_t'(r_state + 3'd1);
                end else if (w_tmo_exp) begin
                    w_state_nxt = ST_SYNC;
                    w_err       = 1'b1;
                    w_err_type  = c_err_tmo;
                end
            end
            ST_CHK: begin
                if (rx_rdy) begin
                    w_state_nxt = ST_SYNC;
                    if (w_sum == c_sum_ok) begin
                        // A clear in the commit cycle frees the output first
                        if (!cmd_rdy || clr_cmd_rdy) begin
                            w_load = 1'b1;
                        end else begin
                            w_err      = 1'b1;
                            w_err_type = c_err_ovr;
                        end
                    end else begin
                        w_err      = 1'b1;
                        w_err_type = c_err_chk;
                    end
                end else if (w_tmo_exp) begin
                    w_state_nxt = ST_SYNC;
                    w_err       = 1'b1;
                    w_err_type  = c_err_tmo;
                end
            end
            default: begin
                w_state_nxt = ST_SYNC;
            end
        endcase
    end

    // Holding registers for the frame body
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_h <= 8'h00;
            r_dhi_h <= 8'h00;
            r_dlo_h <= 8'h00;
        end else if (rx_rdy) begin
            case (r_state)
                ST_CMD:  r_cmd_h <= rx_data;
                ST_DHI:  r_dhi_h <= rx_data;
                ST_DLO:  r_dlo_h <= rx_data;
                default: ;
            endcase
        end
    end

    // Inter-byte timer: idle in SYNC, restarted by each byte and by expiry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= 17'd0;
        end else if ((r_state == ST_SYNC) || rx_rdy || w_tmo_exp) begin
            r_tmo_cnt <= 17'd0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 17'd1;
        end
    end

    // Output registers: command latch, ready flag and error reporting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd      <= 8'h00;
            data     <= 16'h0000;
            cmd_rdy  <= 1'b0;
            cmd_err  <= 1'b0;
            err_type <= 2'b00;
        end else begin
            cmd_err <= w_err;
            if (w_err) begin
                err_type <= w_err_type;
            end
            if (w_load) begin
                cmd     <= r_cmd_h;
                data    <= {r_dhi_h, r_dlo_h};
                cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_deframer.sv
//------------------------------------------------------------------------------
// Module      : tb_uart_cmd_deframer
// Description : Directed self-checking bench for uart_cmd_deframer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_cmd_deframer;

    localparam int TMO = 200;
    localparam int GAP = 80;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        clr_rx_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        cmd_err;
    logic [1:0]  err_type;

    int n_pass  = 0;
    int n_total = 0;
    int mon_err = 0;
    int err_cnt = 0;

    uart_cmd_deframer #(
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_rdy      (rx_rdy),
        .clr_rx_rdy  (clr_rx_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .cmd         (cmd),
        .data        (data),
        .cmd_rdy     (cmd_rdy),
        .cmd_err     (cmd_err),
        .err_type    (err_type)
    );

    always #5 clk = ~clk;

    // Watches clr_rx_rdy against rx_rdy and counts cycles with cmd_err high
    always @(posedge clk) begin
        #2;
        if (clr_rx_rdy !== rx_rdy) mon_err++;
        if (cmd_err === 1'b1) err_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Present one byte for exactly one rising edge; returns 1 time unit after it
    task automatic send_byte(input logic [7:0] b, input logic clr);
        @(negedge clk);
        rx_data     = b;
        rx_rdy      = 1'b1;
        clr_cmd_rdy = clr;
        @(posedge clk);
        #1;
        rx_rdy      = 1'b0;
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic send_frame(input logic [39:0] f);
        for (int i = 4; i >= 0; i--) begin
            if (i != 4) idle(GAP);
            send_byte(f[i*8 +: 8], 1'b0);
        end
    endtask

    task automatic clear_rdy();
        @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1;
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic test_reset();
        n_total++; if ({cmd, data} !== 24'h0) $display("FAIL reset_cmd_data got %h want 000000", {cmd, data}); else n_pass++;
        n_total++; if ({cmd_rdy, cmd_err, err_type} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {cmd_rdy, cmd_err, err_type}); else n_pass++;
    endtask

    task automatic test_valid();
        int e0 = err_cnt;
        send_byte(8'hA5, 1'b0); idle(GAP);
        send_byte(8'h12, 1'b0); idle(GAP);
        send_byte(8'h34, 1'b0); idle(GAP);
        send_byte(8'h56, 1'b0); idle(GAP);
        n_total++; if (cmd_rdy !== 1'b0) $display("FAIL valid_pre_rdy got %b want 0", cmd_rdy); else n_pass++;
        send_byte(8'h63, 1'b0);
        n_total++; if (cmd_rdy !== 1'b1) $display("FAIL valid_rdy got %b want 1", cmd_rdy); else n_pass++;
        n_total++; if ({cmd, data} !== 24'h123456) $display("FAIL valid_cmd_data got %h want 123456", {cmd, data}); else n_pass++;
        idle(3);
        n_total++; if (err_cnt !== e0) $display("FAIL valid_no_err got %0d want %0d", err_cnt, e0); else n_pass++;
        clear_rdy();
        n_total++; if (cmd_rdy !== 1'b0) $display("FAIL clear_rdy got %b want 0", cmd_rdy); else n_pass++;
        n_total++; if ({cmd, data} !== 24'h123456) $display("FAIL clear_keeps got %h want 123456", {cmd, data}); else n_pass++;
    endtask

    task automatic test_checksum();
        int e0 = err_cnt;
        send_frame(40'hA5_12_34_56_64);
        n_total++; if ({cmd_err, err_type} !== 3'b101) $display("FAIL chk_err got %b want 101", {cmd_err, err_type}); else n_pass++;
        n_total++; if (cmd_rdy !== 1'b0) $display("FAIL chk_rdy got %b want 0", cmd_rdy); else n_pass++;
        idle(1); #1;
        n_total++; if (cmd_err !== 1'b0) $display("FAIL chk_pulse_width got %b want 0", cmd_err); else n_pass++;
        n_total++; if (err_cnt !== e0 + 1) $display("FAIL chk_err_count got %0d want %0d", err_cnt, e0 + 1); else n_pass++;
        idle(GAP);
        send_frame(40'hA5_01_00_02_FC);
        n_total++; if ({cmd_rdy, cmd, data} !== 25'h1_01_0002) $display("FAIL chk_next got %h want 1010002", {cmd_rdy, cmd, data}); else n_pass++;
        clear_rdy();
    endtask

    task automatic test_garbage();
        int e0 = err_cnt;
        send_byte(8'h00, 1'b0); idle(GAP);
        send_byte(8'hFF, 1'b0); idle(GAP);
        send_byte(8'h5A, 1'b0); idle(GAP);
        send_frame(40'hA5_12_34_56_63);
        n_total++; if ({cmd_rdy, cmd, data} !== 25'h1_12_3456) $display("FAIL garbage_frame got %h want 1123456", {cmd_rdy, cmd, data}); else n_pass++;
        idle(2);
        n_total++; if (err_cnt !== e0) $display("FAIL garbage_no_err got %0d want %0d", err_cnt, e0); else n_pass++;
        clear_rdy();
    endtask

    task automatic test_timeout();
        int e0 = err_cnt;
        send_byte(8'hA5, 1'b0); idle(GAP);
        send_byte(8'h12, 1'b0);
        idle(TMO - 1); #1;
        n_total++; if (cmd_err !== 1'b0) $display("FAIL tmo_early got %b want 0", cmd_err); else n_pass++;
        idle(1); #1;
        n_total++; if ({cmd_err, err_type} !== 3'b110) $display("FAIL tmo_err got %b want 110", {cmd_err, err_type}); else n_pass++;
        idle(TMO + 50);
        n_total++; if (err_cnt !== e0 + 1) $display("FAIL tmo_single got %0d want %0d", err_cnt, e0 + 1); else n_pass++;
        send_frame(40'hA5_22_00_01_DC);
        n_total++; if ({cmd_rdy, cmd, data} !== 25'h1_22_0001) $display("FAIL tmo_fresh got %h want 1220001", {cmd_rdy, cmd, data}); else n_pass++;
        clear_rdy();
        // Byte landing exactly on the expiry edge must win
        e0 = err_cnt;
        send_byte(8'hA5, 1'b0);
        idle(TMO - 1);
        send_byte(8'h12, 1'b0); idle(GAP);
        send_byte(8'h34, 1'b0); idle(GAP);
        send_byte(8'h56, 1'b0); idle(GAP);
        send_byte(8'h63, 1'b0);
        n_total++; if ({cmd_rdy, cmd, data} !== 25'h1_12_3456) $display("FAIL tmo_byte_wins got %h want 1123456", {cmd_rdy, cmd, data}); else n_pass++;
        n_total++; if (err_cnt !== e0) $display("FAIL tmo_byte_wins_err got %0d want %0d", err_cnt, e0); else n_pass++;
    endtask

    task automatic test_overrun();
        // cmd_rdy is still set from the previous frame (cmd=12)
        send_frame(40'hA5_22_00_01_DC);
        n_total++; if ({cmd_err, err_type} !== 3'b111) $display("FAIL ovr_err got %b want 111", {cmd_err, err_type}); else n_pass++;
        n_total++; if ({cmd_rdy, cmd, data} !== 25'h1_12_3456) $display("FAIL ovr_keep got %h want 1123456", {cmd_rdy, cmd, data}); else n_pass++;
        idle(GAP);
        send_byte(8'hA5, 1'b0); idle(GAP);
        send_byte(8'h22, 1'b0); idle(GAP);
        send_byte(8'h00, 1'b0); idle(GAP);
        send_byte(8'h01, 1'b0); idle(GAP);
        send_byte(8'hDC, 1'b1);
        n_total++; if ({cmd_rdy, cmd, data} !== 25'h1_22_0001) $display("FAIL clr_commit got %h want 1220001", {cmd_rdy, cmd, data}); else n_pass++;
        n_total++; if (cmd_err !== 1'b0) $display("FAIL clr_commit_err got %b want 0", cmd_err); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        send_byte(8'hA5, 1'b0); idle(GAP);
        send_byte(8'h12, 1'b0); idle(GAP);
        send_byte(8'h34, 1'b0); idle(GAP);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_total++; if ({cmd_rdy, cmd, data, err_type} !== 27'h0) $display("FAIL midrst_outputs got %h want 0", {cmd_rdy, cmd, data, err_type}); else n_pass++;
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        send_frame(40'hA5_12_34_56_63);
        n_total++; if ({cmd_rdy, cmd, data} !== 25'h1_12_3456) $display("FAIL midrst_frame got %h want 1123456", {cmd_rdy, cmd, data}); else n_pass++;
    endtask

    task automatic test_clr_rx_rdy();
        n_total++; if (mon_err !== 0) $display("FAIL clr_rx_rdy_follow got %0d mismatching cycles want 0", mon_err); else n_pass++;
    endtask

    initial begin
        rst_n       = 1'b0;
        rx_data     = 8'h00;
        rx_rdy      = 1'b0;
        clr_cmd_rdy = 1'b0;
        idle(3); #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        test_valid();
        idle(GAP);
        test_checksum();
        idle(GAP);
        test_garbage();
        idle(GAP);
        test_timeout();
        idle(GAP);
        test_overrun();
        idle(GAP);
        test_reset_midframe();
        idle(5);
        test_clr_rx_rdy();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
